fog_param_uart_rx: RTL and testbench

UART command receiver and parameter register bank for the FOG core. It deserialises host bytes arriving on FPGA_RX and parses fixed 8-byte command frames. Validated frames update the closed-loop parameter set consumed by HINS_fog_v1 (var_freq_cnt … var_const_step), replacing the constant tie-offs in the top level. The block runs entirely in the CPU clock domain.

---
 rtl/fog_param_uart_rx.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_fog_param_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fog_param_uart_rx.sv
// UART command receiver and parameter register bank for the FOG core.
// Deserialises 8N1 bytes on rx_i and commits checksummed 8-byte frames into the closed-loop parameter set.
module fog_param_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic        pll_clk_cpu_int,
    input  logic        RST_EXT_N,
    input  logic        rx_i,
    output logic [31:0] var_freq_cnt,
    output logic [31:0] var_amp_H,
    output logic [31:0] var_amp_L,
    output logic [31:0] var_wait_cnt,
    output logic [31:0] var_err_offset,
    output logic [31:0] var_avg_sel,
    output logic [31:0] var_gain_sel,
    output logic [31:0] var_fb_ON,
    output logic [31:0] var_const_step,
    output logic        var_polarity,
    output logic        param_upd,
    output logic        cmd_err,
    output logic        frm_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        FR_HDR0 = 3'd0,
        FR_HDR1 = 3'd1,
        FR_ADDR = 3'd2,
        FR_DATA = 3'd3,
        FR_CHK  = 3'd4
    } fr_state_e;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frm_err_q, frm_err_d;

    fr_state_e       fr_state_q, fr_state_d;
    logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [7:0]      chk_q, chk_d;
    logic [1:0]      data_cnt_q, data_cnt_d;

    logic [31:0]     freq_cnt_q, freq_cnt_d, amp_h_q, amp_h_d, amp_l_q, amp_l_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d, err_offset_q, err_offset_d;
    logic [31:0]     avg_sel_q, avg_sel_d, gain_sel_q, gain_sel_d;
    logic [31:0]     fb_on_q, fb_on_d, const_step_q, const_step_d;
    logic            polarity_q, polarity_d;
    logic            param_upd_q, param_upd_d, cmd_err_q, cmd_err_d;
    logic            commit_s;

    // RX synchroniser; the third flop keeps history for falling-edge detection
    always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
        if (!RST_EXT_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Byte FSM state register and datapath flops
    always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
        if (!RST_EXT_N) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frm_err_q    <= frm_err_d;
        end
    end

    // Byte FSM next-state logic
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
                else                         rx_state_d = RX_IDLE;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                else                        rx_state_d = RX_START;
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                else                                            rx_state_d = RX_DATA;
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) rx_state_d = RX_IDLE;
                else                       rx_state_d = RX_STOP;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Byte FSM outputs: bit timing, LSB-first shifting, byte/frame-error pulses
    always_comb begin
        clk_cnt_d    = clk_cnt_q + CW'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frm_err_d    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = 3'd0;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) clk_cnt_d = '0;
                else                        clk_cnt_d = clk_cnt_q + CW'(1);
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frm_err_d    = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: clk_cnt_d = '0;
        endcase
    end

    // Frame FSM state register and frame datapath flops
    always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
        if (!RST_EXT_N) begin
            fr_state_q <= FR_HDR0;
            idle_cnt_q <= '0;
            addr_q     <= 8'h00;
            shadow_q   <= 32'h0000_0000;
            chk_q      <= 8'h00;
            data_cnt_q <= 2'd0;
        end else begin
            fr_state_q <= fr_state_d;
            idle_cnt_q <= idle_cnt_d;
            addr_q     <= addr_d;
            shadow_q   <= shadow_d;
            chk_q      <= chk_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    // Frame FSM next-state logic; a framing error or inter-byte timeout resyncs to HDR0
    always_comb begin
        fr_state_d = fr_state_q;
        if (frm_err_q) begin
            fr_state_d = FR_HDR0;
        end else if (byte_valid_q) begin
            case (fr_state_q)
                FR_HDR0: fr_state_d = (byte_q == 8'hAB) ? FR_HDR1 : FR_HDR0;
                FR_HDR1: begin
                    if (byte_q == 8'hBA)      fr_state_d = FR_ADDR;
                    else if (byte_q == 8'hAB) fr_state_d = FR_HDR1;
                    else                      fr_state_d = FR_HDR0;
                end
                FR_ADDR: fr_state_d = FR_DATA;
                FR_DATA: fr_state_d = (data_cnt_q == 2'd3) ? FR_CHK : FR_DATA;
                FR_CHK:  fr_state_d = FR_HDR0;
                default: fr_state_d = FR_HDR0;
            endcase
        end else if (fr_state_q != FR_HDR0 && idle_cnt_q == TO_LAST) begin
            fr_state_d = FR_HDR0;
        end else begin
            fr_state_d = fr_state_q;
        end
    end

    // Frame FSM outputs: address latch, big-endian data shadow, running checksum, idle timer
    always_comb begin
        addr_d     = addr_q;
        shadow_d   = shadow_q;
        chk_d      = chk_q;
        data_cnt_d = data_cnt_q;
        if (fr_state_q == FR_HDR0 || byte_valid_q) idle_cnt_d = '0;
        else                                       idle_cnt_d = idle_cnt_q + TW'(1);
        if (byte_valid_q) begin
            case (fr_state_q)
                FR_ADDR: begin
                    addr_d     = byte_q;
                    chk_d      = byte_q;
                    data_cnt_d = 2'd0;
                end
                FR_DATA: begin
                    shadow_d   = {shadow_q[23:0], byte_q};
                    chk_d      = chk_update(chk_q, byte_q);
                    data_cnt_d = data_cnt_q + 2'd1;
                end
                default: data_cnt_d = data_cnt_q;
            endcase
        end else begin
            data_cnt_d = data_cnt_q;
        end
    end

    assign commit_s = byte_valid_q && (fr_state_q == FR_CHK);

    // Register bank write decode; bad checksum or unmapped address flags cmd_err instead
    always_comb begin
        freq_cnt_d   = freq_cnt_q;
        amp_h_d      = amp_h_q;
        amp_l_d      = amp_l_q;
        polarity_d   = polarity_q;
        wait_cnt_d   = wait_cnt_q;
        err_offset_d = err_offset_q;
        avg_sel_d    = avg_sel_q;
        gain_sel_d   = gain_sel_q;
        fb_on_d      = fb_on_q;
        const_step_d = const_step_q;
        param_upd_d  = 1'b0;
        cmd_err_d    = 1'b0;
        if (commit_s) begin
            if (byte_q == chk_q) begin
                param_upd_d = 1'b1;
                case (addr_q)
                    8'h01:   freq_cnt_d   = shadow_q;
                    8'h02:   amp_h_d      = shadow_q;
                    8'h03:   amp_l_d      = shadow_q;
                    8'h04:   polarity_d   = shadow_q[0];
                    8'h05:   wait_cnt_d   = shadow_q;
                    8'h06:   err_offset_d = shadow_q;
                    8'h07:   avg_sel_d    = shadow_q;
                    8'h08:   gain_sel_d   = shadow_q;
                    8'h09:   fb_on_d      = shadow_q;
                    8'h0A:   const_step_d = shadow_q;
                    default: begin
                        param_upd_d = 1'b0;
                        cmd_err_d   = 1'b1;
                    end
                endcase
            end else begin
                cmd_err_d = 1'b1;
            end
        end else begin
            cmd_err_d = 1'b0;
        end
    end

    // Parameter registers and commit pulses
    always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
        if (!RST_EXT_N) begin
            freq_cnt_q   <= 32'd1000;
            amp_h_q      <= 32'd5000;
            amp_l_q      <= 32'd5000;
            polarity_q   <= 1'b0;
            wait_cnt_q   <= 32'd50;
            err_offset_q <= 32'd0;
            avg_sel_q    <= 32'd10;
            gain_sel_q   <= 32'd5;
            fb_on_q      <= 32'd1;
            const_step_q <= 32'd100;
            param_upd_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            freq_cnt_q   <= freq_cnt_d;
            amp_h_q      <= amp_h_d;
            amp_l_q      <= amp_l_d;
            polarity_q   <= polarity_d;
            wait_cnt_q   <= wait_cnt_d;
            err_offset_q <= err_offset_d;
            avg_sel_q    <= avg_sel_d;
            gain_sel_q   <= gain_sel_d;
            fb_on_q      <= fb_on_d;
            const_step_q <= const_step_d;
            param_upd_q  <= param_upd_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign var_freq_cnt   = freq_cnt_q;
    assign var_amp_H      = amp_h_q;
    assign var_amp_L      = amp_l_q;
    assign var_polarity   = polarity_q;
    assign var_wait_cnt   = wait_cnt_q;
    assign var_err_offset = err_offset_q;
    assign var_avg_sel    = avg_sel_q;
    assign var_gain_sel   = gain_sel_q;
    assign var_fb_ON      = fb_on_q;
    assign var_const_step = const_step_q;
    assign param_upd      = param_upd_q;
    assign cmd_err        = cmd_err_q;
    assign frm_err        = frm_err_q;

endmodule

// File: tb/tb_fog_param_uart_rx.sv
// Scoreboard bench for fog_param_uart_rx: directed UART frames push expected pulses and register snapshots,
// a monitor pops and compares on every param_upd / cmd_err / frm_err pulse.
module tb_fog_param_uart_rx;

    localparam int CPB = 16;
    localparam int TOC = 1000;
    localparam logic [2:0] K_UPD = 3'b001;
    localparam logic [2:0] K_CMD = 3'b010;
    localparam logic [2:0] K_FRM = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] var_freq_cnt, var_amp_H, var_amp_L, var_wait_cnt, var_err_offset;
    logic [31:0] var_avg_sel, var_gain_sel, var_fb_ON, var_const_step;
    logic        var_polarity, param_upd, cmd_err, frm_err;

    typedef struct packed {
        logic [2:0]   kind;
        logic [288:0] regs;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run = 0;
    int          fails = 0;
    int          pulse_cnt = 0;
    logic [31:0] m_var [0:8];
    logic        m_pol;

    always #5 clk = ~clk;

    fog_param_uart_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOC)) dut (
        .pll_clk_cpu_int(clk),
        .RST_EXT_N(rst_n),
        .rx_i(rx),
        .var_freq_cnt(var_freq_cnt),
        .var_amp_H(var_amp_H),
        .var_amp_L(var_amp_L),
        .var_wait_cnt(var_wait_cnt),
        .var_err_offset(var_err_offset),
        .var_avg_sel(var_avg_sel),
        .var_gain_sel(var_gain_sel),
        .var_fb_ON(var_fb_ON),
        .var_const_step(var_const_step),
        .var_polarity(var_polarity),
        .param_upd(param_upd),
        .cmd_err(cmd_err),
        .frm_err(frm_err)
    );

    function automatic logic [288:0] dut_pack();
        return {var_freq_cnt, var_amp_H, var_amp_L, var_wait_cnt, var_err_offset,
                var_avg_sel, var_gain_sel, var_fb_ON, var_const_step, var_polarity};
    endfunction

    function automatic logic [288:0] model_pack();
        return {m_var[0], m_var[1], m_var[2], m_var[3], m_var[4],
                m_var[5], m_var[6], m_var[7], m_var[8], m_pol};
    endfunction

    task automatic model_reset();
        m_var[0] = 32'd1000; m_var[1] = 32'd5000; m_var[2] = 32'd5000;
        m_var[3] = 32'd50;   m_var[4] = 32'd0;    m_var[5] = 32'd10;
        m_var[6] = 32'd5;    m_var[7] = 32'd1;    m_var[8] = 32'd100;
        m_pol    = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [288:0] act, input logic [288:0] expv);
        tests_run++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.regs = model_pack();
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check_val(name, 289'(exp_q.size()), 289'd0);
        repeat (50) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        model_reset();
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (param_upd || cmd_err || frm_err) begin
                        pulse_cnt++;
                        if (exp_q.size() == 0) begin
                            tests_run++;
                            fails++;
                            $display("FAIL unexpected_pulse actual=%b expected=none",
                                     {frm_err, cmd_err, param_upd});
                        end else begin
                            e = exp_q.pop_front();
                            check_val("pulse_kind", 289'({frm_err, cmd_err, param_upd}), 289'(e.kind));
                            check_val("regs_at_pulse", dut_pack(), e.regs);
                        end
                    end
                end
            end
        join_none

        // Reset and quiet line
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_regs", dut_pack(), model_pack());
        check_val("reset_pulses", 289'({frm_err, cmd_err, param_upd}), 289'd0);
        repeat (10000) @(negedge clk);
        check_val("idle_no_pulses", 289'(pulse_cnt), 289'd0);

        // Bad checksum: freq_cnt stays 1000
        push_exp(K_CMD);
        send_frame(64'hABBA_0100_0007_D0D7);
        wait_drain("drain_bad_chk");

        // Good write freq_cnt = 2000
        m_var[0] = 32'd2000;
        push_exp(K_UPD);
        send_frame(64'hABBA_0100_0007_D0D6);
        wait_drain("drain_freq");

        // Unknown address with valid checksum
        push_exp(K_CMD);
        send_frame(64'hABBA_0F00_0000_010E);
        wait_drain("drain_bad_addr");

        // Header resync via repeated AB
        m_pol = 1'b1;
        push_exp(K_UPD);
        send_byte(8'hAB, 1'b0);
        send_frame(64'hABBA_0400_0000_0307);
        wait_drain("drain_polarity");

        // Stop-bit error on the third byte, then a clean frame
        push_exp(K_FRM);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hBA, 1'b0);
        send_byte(8'h01, 1'b1);
        wait_drain("drain_frm_err");
        m_var[8] = 32'd100;
        push_exp(K_UPD);
        send_frame(64'hABBA_0A00_0000_646E);
        wait_drain("drain_const_step");

        // Inter-byte timeout discards the frame
        snap = pulse_cnt;
        send_byte(8'hAB, 1'b0);
        send_byte(8'hBA, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (1200) @(negedge clk);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h9B, 1'b0);
        repeat (100) @(negedge clk);
        check_val("timeout_no_pulse", 289'(pulse_cnt - snap), 289'd0);
        check_val("timeout_regs", dut_pack(), model_pack());
        m_var[1] = 32'd5000;
        push_exp(K_UPD);
        send_frame(64'hABBA_0200_0013_8899);
        wait_drain("drain_amp_h");

        // Reset mid-byte
        rx = 1'b0;
        repeat (CPB * 4) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        model_reset();
        check_val("midbyte_reset_regs", dut_pack(), model_pack());
        check_val("midbyte_reset_pulses", 289'({frm_err, cmd_err, param_upd}), 289'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB * 4) @(negedge clk);
        check_val("post_reset_regs", dut_pack(), model_pack());

        // Full 32-bit big-endian write after reset
        m_var[5] = 32'h1234_5678;
        push_exp(K_UPD);
        send_frame(64'hABBA_0712_3456_780F);
        wait_drain("drain_avg_sel");

        check_val("final_regs", dut_pack(), model_pack());
        check_val("final_queue_empty", 289'(exp_q.size()), 289'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
